// File: rtl/dm_arbiter.sv
// dm_arbiter
// ----------
// Two-requester round-robin arbiter in front of the single-port 8-bit data
// memory (dat_mem). Requester 0 is the core load/store unit, requester 1 is
// the bench loader / DMA-style helper. Exactly one access reaches dat_mem in
// a grant cycle; read data is captured into a per-requester register and
// presented one cycle later with a one-cycle rvalid pulse.
//
// A requester may hold its grant across consecutive cycles by asserting lock,
// but a burst is capped at LOCK_MAX grants so the other side cannot starve.
//
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   rN_req/lock/we          requester N request, burst lock, write select
//   rN_addr/wdata           requester N address and write data
//   rN_gnt                  access performed this cycle (combinational)
//   rN_rvalid/rdata         registered read data and its one-cycle pulse
//   mem_wr_en/addr/dat_in   drive dat_mem
//   mem_dat_out             dat_mem combinational read data
//
// Optional build macro DM_ARB_STATS_EN adds the saturating counters
// r0_gnt_cnt, r1_gnt_cnt and conflict_cnt (16 bits each).

module dm_arbiter #(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          r0_req,
  input  logic          r0_lock,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,

  input  logic          r1_req,
  input  logic          r1_lock,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,

`ifdef DM_ARB_STATS_EN
  output logic [15:0]   r0_gnt_cnt,
  output logic [15:0]   r1_gnt_cnt,
  output logic [15:0]   conflict_cnt,
`endif

  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  // A lock of one grant is no lock at all, so LOCK_MAX=1 never leaves ARB.
  localparam bit CAN_LOCK = (LOCK_MAX > 1);

  state_t     state;
  logic       last;       // index of the most recent grant; loser of next tie
  logic [3:0] lock_cnt;   // grants already given in the current locked burst
  logic       lock_more;  // one more locked grant still fits under LOCK_MAX

  assign lock_more = ((int'(lock_cnt) + 1) < LOCK_MAX);

  // Grant decision. Reset masks everything so nothing reaches dat_mem while
  // reset is high. In a locked state the owner keeps the port while it
  // requests; if the owner idles, the other side may use that cycle.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (!reset) begin
      unique case (state)
        ARB: begin
          if (r0_req && r1_req) begin
            if (last) r0_gnt = 1'b1;
            else      r1_gnt = 1'b1;
          end else begin
            r0_gnt = r0_req;
            r1_gnt = r1_req;
          end
        end
        LOCK0: begin
          if (r0_req) r0_gnt = 1'b1;
          else        r1_gnt = r1_req;
        end
        LOCK1: begin
          if (r1_req) r1_gnt = 1'b1;
          else        r0_gnt = r0_req;
        end
        default: begin
          r0_gnt = 1'b0;
          r1_gnt = 1'b0;
        end
      endcase
    end
  end

  // Memory mux: requester 0's fields are the idle default, so the address
  // bus only moves to requester 1 on its grant cycles.
  always_comb begin
    mem_addr   = r0_addr;
    mem_dat_in = r0_wdata;
    if (r1_gnt) begin
      mem_addr   = r1_addr;
      mem_dat_in = r1_wdata;
    end
    mem_wr_en = (r0_gnt && r0_we) || (r1_gnt && r1_we);
  end

  // Arbitration state: burst tracking and round-robin history. A locked
  // burst ends on the owner dropping lock, the owner idling, or the cap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB;
      last     <= 1'b1;
      lock_cnt <= 4'd0;
    end else begin
      if (r0_gnt)      last <= 1'b0;
      else if (r1_gnt) last <= 1'b1;

      unique case (state)
        ARB: begin
          if (r0_gnt && r0_lock && CAN_LOCK) begin
            state    <= LOCK0;
            lock_cnt <= 4'd1;
          end else if (r1_gnt && r1_lock && CAN_LOCK) begin
            state    <= LOCK1;
            lock_cnt <= 4'd1;
          end
        end
        LOCK0: begin
          if (r0_gnt && r0_lock && lock_more) begin
            lock_cnt <= lock_cnt + 4'd1;
          end else begin
            state    <= ARB;
            lock_cnt <= 4'd0;
          end
        end
        LOCK1: begin
          if (r1_gnt && r1_lock && lock_more) begin
            lock_cnt <= lock_cnt + 4'd1;
          end else begin
            state    <= ARB;
            lock_cnt <= 4'd0;
          end
        end
        default: begin
          state    <= ARB;
          lock_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Read capture: the memory answers combinationally in the grant cycle, so
  // the data is registered at that edge and flagged valid for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r0_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rvalid <= 1'b0;
      r1_rdata  <= '0;
    end else begin
      r0_rvalid <= r0_gnt && !r0_we;
      r1_rvalid <= r1_gnt && !r1_we;
      if (r0_gnt && !r0_we) r0_rdata <= mem_dat_out;
      if (r1_gnt && !r1_we) r1_rdata <= mem_dat_out;
    end
  end

`ifdef DM_ARB_STATS_EN
  // A conflict cycle is any cycle where someone asked and was turned away,
  // either by a tie or by the other side's lock.
  logic conflict;
  assign conflict = (r0_req && r1_req) || (r0_req && !r0_gnt) || (r1_req && !r1_gnt);

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r0_gnt_cnt   <= 16'd0;
      r1_gnt_cnt   <= 16'd0;
      conflict_cnt <= 16'd0;
    end else begin
      if (r0_gnt && (r0_gnt_cnt != 16'hFFFF))     r0_gnt_cnt   <= r0_gnt_cnt + 16'd1;
      if (r1_gnt && (r1_gnt_cnt != 16'hFFFF))     r1_gnt_cnt   <= r1_gnt_cnt + 16'd1;
      if (conflict && (conflict_cnt != 16'hFFFF)) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter
// -------------
// Directed bench for dm_arbiter with a small dat_mem model. Inputs change on
// the falling edge; combinational grants are checked 1 time unit later and
// registered read outputs 1 time unit after the rising edge.

module tb_dm_arbiter;

  logic       clk;
  logic       reset;
  logic       r0Req, r0Lock, r0We;
  logic [7:0] r0Addr, r0Wdata;
  logic       r0Gnt, r0Rvalid;
  logic [7:0] r0Rdata;
  logic       r1Req, r1Lock, r1We;
  logic [7:0] r1Addr, r1Wdata;
  logic       r1Gnt, r1Rvalid;
  logic [7:0] r1Rdata;
  logic       memWrEn;
  logic [7:0] memAddr, memDatIn, memDatOut;
`ifdef DM_ARB_STATS_EN
  logic [15:0] r0GntCnt, r1GntCnt, conflictCnt;
`endif

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  dm_arbiter #(.DW(8), .AW(8), .LOCK_MAX(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .r0_req      (r0Req),
    .r0_lock     (r0Lock),
    .r0_we       (r0We),
    .r0_addr     (r0Addr),
    .r0_wdata    (r0Wdata),
    .r0_gnt      (r0Gnt),
    .r0_rvalid   (r0Rvalid),
    .r0_rdata    (r0Rdata),
    .r1_req      (r1Req),
    .r1_lock     (r1Lock),
    .r1_we       (r1We),
    .r1_addr     (r1Addr),
    .r1_wdata    (r1Wdata),
    .r1_gnt      (r1Gnt),
    .r1_rvalid   (r1Rvalid),
    .r1_rdata    (r1Rdata),
`ifdef DM_ARB_STATS_EN
    .r0_gnt_cnt  (r0GntCnt),
    .r1_gnt_cnt  (r1GntCnt),
    .conflict_cnt(conflictCnt),
`endif
    .mem_wr_en   (memWrEn),
    .mem_addr    (memAddr),
    .mem_dat_in  (memDatIn),
    .mem_dat_out (memDatOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dat_mem model: unwritten locations read as addr ^ 8'h10, so address
  // 8'h01 reads 8'h11 and 8'h02 reads 8'h12.
  logic [7:0]   memArray [256];
  logic [255:0] written;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      written <= '0;
    end else if (memWrEn) begin
      written[memAddr]  <= 1'b1;
      memArray[memAddr] <= memDatIn;
    end
  end

  assign memDatOut = written[memAddr] ? memArray[memAddr] : (memAddr ^ 8'h10);

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic q0, input logic l0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                               input logic q1, input logic l1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    @(negedge clk);
    r0Req = q0; r0Lock = l0; r0We = w0; r0Addr = a0; r0Wdata = d0;
    r1Req = q1; r1Lock = l1; r1We = w1; r1Addr = a1; r1Wdata = d1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int expR1Lock [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
  int r0Q5      [8]  = '{1, 1, 0, 1, 1, 1, 1, 1};
  int expR1Idle [8]  = '{0, 0, 1, 0, 0, 0, 0, 1};
  int waitRun;
  int maxWait;

  initial begin
    reset = 1'b1;
    r0Req = 1'b1; r0Lock = 1'b0; r0We = 1'b1; r0Addr = 8'h00; r0Wdata = 8'h00;
    r1Req = 1'b1; r1Lock = 1'b0; r1We = 1'b1; r1Addr = 8'h00; r1Wdata = 8'h00;

    // Reset values with both requests raised.
    #1;
    checkOutput("rst_r0_gnt",    16'(r0Gnt),    16'd0);
    checkOutput("rst_r1_gnt",    16'(r1Gnt),    16'd0);
    checkOutput("rst_mem_wr_en", 16'(memWrEn),  16'd0);
    checkOutput("rst_r0_rvalid", 16'(r0Rvalid), 16'd0);
    checkOutput("rst_r1_rvalid", 16'(r1Rvalid), 16'd0);
    checkOutput("rst_r0_rdata",  16'(r0Rdata),  16'd0);
    checkOutput("rst_r1_rdata",  16'(r1Rdata),  16'd0);
    @(negedge clk);
    reset = 1'b0;

    // r0 writes 8'hA5 to 8'h10 alone, then reads it back.
    applyStimulus(1, 0, 1, 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("wr_r0_gnt",     16'(r0Gnt),    16'd1);
    checkOutput("wr_r1_gnt",     16'(r1Gnt),    16'd0);
    checkOutput("wr_mem_wr_en",  16'(memWrEn),  16'd1);
    checkOutput("wr_mem_addr",   16'(memAddr),  16'h10);
    checkOutput("wr_mem_dat_in", 16'(memDatIn), 16'hA5);
    tick();
    checkOutput("wr_no_rvalid",  16'(r0Rvalid), 16'd0);
    applyStimulus(1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("rd_r0_gnt",     16'(r0Gnt),    16'd1);
    checkOutput("rd_mem_wr_en",  16'(memWrEn),  16'd0);
    tick();
    checkOutput("rd_r0_rvalid",  16'(r0Rvalid), 16'd1);
    checkOutput("rd_r0_rdata",   16'(r0Rdata),  16'hA5);
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("idle_gnt",      16'(r0Gnt | r1Gnt), 16'd0);
    tick();
    checkOutput("rvalid_pulse",  16'(r0Rvalid), 16'd0);
    checkOutput("rdata_hold",    16'(r0Rdata),  16'hA5);

    // Alternation from reset: r0, r1, r0, r1.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      checkOutput($sformatf("alt%0d_r0_gnt", i), 16'(r0Gnt), 16'((i % 2) == 0));
      checkOutput($sformatf("alt%0d_r1_gnt", i), 16'(r1Gnt), 16'((i % 2) == 1));
      checkOutput($sformatf("alt%0d_mem_addr", i), 16'(memAddr), ((i % 2) == 0) ? 16'h01 : 16'h02);
      tick();
      checkOutput($sformatf("alt%0d_r0_rvalid", i), 16'(r0Rvalid), 16'((i % 2) == 0));
      checkOutput($sformatf("alt%0d_r1_rvalid", i), 16'(r1Rvalid), 16'((i % 2) == 1));
      if ((i % 2) == 0) checkOutput($sformatf("alt%0d_r0_rdata", i), 16'(r0Rdata), 16'h11);
      else              checkOutput($sformatf("alt%0d_r1_rdata", i), 16'(r1Rdata), 16'h12);
    end

    // r1 locked bursts against a steady r0 request: capped at 4 grants.
    waitRun = 0;
    maxWait = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0, 8'h01, 8'h00, 1, 1, 0, 8'h02, 8'h00);
      checkOutput($sformatf("lock%0d_r1_gnt", i), 16'(r1Gnt), 16'(expR1Lock[i]));
      checkOutput($sformatf("lock%0d_r0_gnt", i), 16'(r0Gnt), 16'(expR1Lock[i] == 0));
      if (r0Gnt) waitRun = 0;
      else       waitRun++;
      if (waitRun > maxWait) maxWait = waitRun;
      tick();
    end
    checkOutput("lock_r0_max_wait_le5", 16'(maxWait <= 5), 16'd1);

    // r0 locked burst, r0 idles one cycle: r1 takes the idle cycle and the
    // burst restarts from a fresh count (four r0 grants before r1 again).
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'(r0Q5[i]), 1, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      checkOutput($sformatf("idle%0d_r1_gnt", i), 16'(r1Gnt), 16'(expR1Idle[i]));
      checkOutput($sformatf("idle%0d_r0_gnt", i), 16'(r0Gnt), 16'(expR1Idle[i] == 0));
      tick();
      if (i == 2) begin
        checkOutput("idle_r1_rvalid", 16'(r1Rvalid), 16'd1);
        checkOutput("idle_r1_rdata",  16'(r1Rdata),  16'h12);
      end
    end

    // Reset during LOCK0 while a read is granted.
    applyStimulus(1, 1, 0, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("rlk_r0_gnt", 16'(r0Gnt), 16'd1);
    tick();
    checkOutput("rlk_r0_rvalid", 16'(r0Rvalid), 16'd1);
    applyStimulus(1, 1, 0, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    reset = 1'b1;
    #1;
    checkOutput("rlk_gnt_masked",   16'(r0Gnt),    16'd0);
    checkOutput("rlk_wr_en_masked", 16'(memWrEn),  16'd0);
    checkOutput("rlk_rvalid_clr",   16'(r0Rvalid), 16'd0);
    tick();
    checkOutput("rlk_rvalid_stays0", 16'(r0Rvalid), 16'd0);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
    checkOutput("post_rst_r0_gnt", 16'(r0Gnt), 16'd1);
    checkOutput("post_rst_r1_gnt", 16'(r1Gnt), 16'd0);
    tick();
    checkOutput("post_rst_r0_rdata", 16'(r0Rdata), 16'h11);
    applyStimulus(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
    checkOutput("post_rst_next_r1_gnt", 16'(r1Gnt), 16'd1);
    tick();

`ifdef DM_ARB_STATS_EN
    // Six contended alternating grants.
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      tick();
    end
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("stats_r0_gnt_cnt",   r0GntCnt,    16'd3);
    checkOutput("stats_r1_gnt_cnt",   r1GntCnt,    16'd3);
    checkOutput("stats_conflict_cnt", conflictCnt, 16'd6);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester round-robin arbiter sharing the single-port 8-bit data memory (dat_mem) between requester 0 (core load/store unit) and requester 1 (bench loader / DMA-style helper).
- Sits between the requesters and dat_mem.
- Drives dat_mem's wr_en, addr and dat_in.
- Captures dat_out into per-requester read registers.
- Supports locked bursts, capped at LOCK_MAX grants, so neither side starves.

Parameters:
- DW, 8, data width, matching dat_mem
- AW, 8, address width, matching dat_mem
- LOCK_MAX, 4, maximum consecutive grants to one requester while it holds lock (1..15)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- rN_req  in  1  requester N (N=0,1) wants an access this cycle
- rN_lock  in  1  requester N asks to keep the grant after this access
- rN_we  in  1  1=write, 0=read
- rN_addr  in  AW  access address
- rN_wdata  in  DW  write data
- rN_gnt  out  1  access performed this cycle (combinational)
- rN_rvalid  out  1  rN_rdata valid; one-cycle pulse
- rN_rdata  out  DW  registered read data
- mem_wr_en  out  1  to dat_mem wr_en
- mem_addr  out  AW  to dat_mem addr
- mem_dat_in  out  DW  to dat_mem dat_in
- mem_dat_out  in  DW  from dat_mem dat_out; combinational read of mem_addr

Behaviour:
- Reset values:
  - state=ARB, last=1 (r0 wins the first tie), lock_cnt=0
  - rN_rvalid=0, rN_rdata=0
  - all rN_gnt=0 and mem_wr_en=0 while reset is high, regardless of requests
- States: ARB, LOCK0, LOCK1.
- ARB:
  - only one req: grant it
  - both req: grant the requester != last
  - none: no grant, mem_wr_en=0, mem_addr/mem_dat_in hold r0 values (don't-care)
- LOCKn:
  - only requester n may be granted while rn_req=1
  - the other requester sees gnt=0 even if requesting
- At most one rN_gnt high per cycle. The transaction occurs in the grant cycle.
- Memory mux: mem_addr/mem_dat_in = granted requester's addr/wdata; mem_wr_en = gnt & we of granted requester.
- Read path: on posedge with rN_gnt=1 and rN_we=0:
  - rN_rdata <= mem_dat_out, rN_rvalid <= 1
  - otherwise rN_rvalid <= 0 and rN_rdata holds
  - Read latency: 1 cycle after grant. Writes produce no rvalid.
- Per grant at posedge: last <= granted index.
- Transitions:
  - ARB->LOCKn: when n granted with rn_lock=1 and LOCK_MAX>1; lock_cnt <= 1.
  - LOCKn->LOCKn: n granted with rn_lock=1 and lock_cnt+1 < LOCK_MAX; lock_cnt increments.
  - LOCKn->ARB, any of:
    - rn_lock=0 on a granted cycle
    - rn_req=0 (no grant that cycle; idle cycle ends the lock)
    - lock_cnt+1 reaches LOCK_MAX
  - lock_cnt <= 0 on every return to ARB.
- Fairness after a capped lock: last=n, so in ARB the other requester wins a tie. The max wait for a requesting port is LOCK_MAX+1 cycles.
- Simultaneous read by one port and write by the other in ARB: only one is granted. The loser retries by holding req. Requesters must hold addr/we/wdata stable while req=1 and gnt=0.
- Reset asserted mid-burst: state returns to ARB immediately; rvalid pulses are dropped.

Optional Feature:
- Macro DM_ARB_STATS_EN.
- Defined:
  - adds outputs r0_gnt_cnt and r1_gnt_cnt (16 bits each), reset to 0
  - each increments on its requester's granted cycles and saturates at 16'hFFFF
  - adds output conflict_cnt (16 bits, saturating), incrementing on cycles where both req=1 or a locked-out req=1 sees no grant
- Undefined: these ports and registers do not exist; arbitration behaviour is identical.

Test Plan:
- Reset, then r0 writes addr 8'h10 data 8'hA5 alone -> r0_gnt=1 same cycle, mem_wr_en=1, mem_addr=8'h10; r0 reads 8'h10 next -> r0_rvalid=1 one cycle later with r0_rdata=8'hA5.
- Both req continuously, no lock, reads of 8'h01 (r0) and 8'h02 (r1) -> grants alternate r0,r1,r0,r1 starting with r0 after reset; each rvalid follows its grant by 1 cycle.
- r1 req+lock for 10 cycles while r0 req held, LOCK_MAX=4 -> r1 granted 4 consecutive cycles, then r0 granted 1 cycle, then r1 4 more; r0 never waits more than 5 cycles.
- r0 lock burst, r0_req drops for 1 cycle mid-burst while r1 requesting -> r1 granted in that idle cycle; state returns to ARB.
- Reset pulse during LOCK0 with a read granted the same cycle -> r0_gnt drops while reset is high, r0_rvalid stays 0, next access after release obeys the last=1 tie rule.
- With DM_ARB_STATS_EN: 6 alternating contended grants -> r0_gnt_cnt=3, r1_gnt_cnt=3, conflict_cnt=6.
